// File: rtl/decode_pkg.sv
// Shared types and opcode map for the lab CPU decode stage.
package decode_pkg;

   // Field order matches out_ctrl: {RegWrite,RegDst,ALUSrc1,ALUSrc2,MemWrite,MemToReg,RegSrc,ALUOp}
   typedef struct packed {
      logic       reg_write;
      logic       reg_dst;
      logic       alu_src1;
      logic       alu_src2;
      logic       mem_write;
      logic       mem_to_reg;
      logic       reg_src;
      logic [3:0] alu_op;
   } ctrl_t;

   typedef enum logic [1:0] {
      IMM_NONE,
      IMM_7,
      IMM_NZ6,
      IMM_OFF9
   } imm_sel_t;

   localparam logic [3:0] OP_LD   = 4'h0;
   localparam logic [3:0] OP_ST   = 4'h1;
   localparam logic [3:0] OP_MV   = 4'h2;
   localparam logic [3:0] OP_LI   = 4'h3;
   localparam logic [3:0] OP_ADD  = 4'h4;
   localparam logic [3:0] OP_ADDI = 4'h5;
   localparam logic [3:0] OP_SUB  = 4'h6;
   localparam logic [3:0] OP_MUL  = 4'h7;
   localparam logic [3:0] OP_SLLI = 4'h8;
   localparam logic [3:0] OP_SRLI = 4'h9;
   localparam logic [3:0] OP_BR0  = 4'hA;
   localparam logic [3:0] OP_BR1  = 4'hB;

   // Packs the seven one-bit control flags (MSB = RegWrite) with the ALU op.
   function automatic ctrl_t mk_ctrl(input logic [6:0] flags, input logic [3:0] alu_op);
      ctrl_t c;
      c = {flags, alu_op};
      return c;
   endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
interface decode_stage_if #(
   parameter int DATA_W = 16,
   parameter int PC_W   = 8
);
   import decode_pkg::*;

   logic              in_valid;
   logic              in_ready;
   logic [15:0]       in_instr;
   logic [PC_W-1:0]   in_pc;
   logic              out_valid;
   logic              out_ready;
   ctrl_t             out_ctrl;
   logic [DATA_W-1:0] out_imm;
   logic [PC_W-1:0]   out_pc;
   logic              out_illegal;

   // Environment side: drives instructions in and accepts bundles out.
   modport master (
      output in_valid, in_instr, in_pc, out_ready,
      input  in_ready, out_valid, out_ctrl, out_imm, out_pc, out_illegal
   );

   // Decode stage side.
   modport slave (
      input  in_valid, in_instr, in_pc, out_ready,
      output in_ready, out_valid, out_ctrl, out_imm, out_pc, out_illegal
   );
endinterface

// File: rtl/decode_lut.sv
// Opcode to control-bundle lookup; purely combinational.
module decode_lut
   import decode_pkg::*;
(
   input  logic [3:0] opcode,
   input  logic [5:0] nz6,
   output ctrl_t      ctrl,
   output imm_sel_t   imm_sel,
   output logic       illegal
);

   logic nz6_zero;
   assign nz6_zero = (nz6 == 6'd0);

   // Table decode; illegal words leave ctrl at zero and select no immediate.
   always_comb begin
      ctrl    = '0;
      imm_sel = IMM_NONE;
      illegal = 1'b0;
      case (opcode)
         OP_LD:   begin ctrl = mk_ctrl(7'b1101010, 4'd0); imm_sel = IMM_7;    end
         OP_ST:   begin ctrl = mk_ctrl(7'b0001100, 4'd0); imm_sel = IMM_7;    end
         OP_MV:   begin ctrl = mk_ctrl(7'b1100001, 4'd0);                     end
         OP_ADD:  begin ctrl = mk_ctrl(7'b1100001, 4'd2);                     end
         OP_ADDI: begin ctrl = mk_ctrl(7'b1101001, 4'd2); imm_sel = IMM_7;    end
         OP_SUB:  begin ctrl = mk_ctrl(7'b1100001, 4'd3);                     end
         OP_MUL:  begin ctrl = mk_ctrl(7'b1100001, 4'd8);                     end
         OP_BR0:  begin ctrl = mk_ctrl(7'b0010000, 4'd6); imm_sel = IMM_OFF9; end
         OP_BR1:  begin ctrl = mk_ctrl(7'b0010000, 4'd7); imm_sel = IMM_OFF9; end
         OP_LI: begin
            if (nz6_zero) illegal = 1'b1;
            else begin ctrl = mk_ctrl(7'b1101001, 4'd0); imm_sel = IMM_NZ6; end
         end
         OP_SLLI: begin
            if (nz6_zero) illegal = 1'b1;
            else begin ctrl = mk_ctrl(7'b1101001, 4'd4); imm_sel = IMM_NZ6; end
         end
         OP_SRLI: begin
            if (nz6_zero) illegal = 1'b1;
            else begin ctrl = mk_ctrl(7'b1101001, 4'd5); imm_sel = IMM_NZ6; end
         end
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage between fetch and execute: one output register,
// valid/ready on both sides, flush, and a saturating illegal-word counter.
module decode_stage
   import decode_pkg::*;
#(
   parameter int DATA_W    = 16,
   parameter int PC_W      = 8,
   parameter bit SEXT_IMM  = 1'b1,
   parameter int ILL_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   decode_stage_if.slave        bus,
   output logic [ILL_CNT_W-1:0] ill_count
);

   ctrl_t             dec_ctrl;
   imm_sel_t          dec_imm_sel;
   logic              dec_illegal;
   logic              accept;
   logic              sext_en;
   logic [8:0]        imm_f9;
   logic [DATA_W-1:0] imm_ext;
   logic [2:0]        unused_instr_bits;

   assign unused_instr_bits = bus.in_instr[11:9];

   assign bus.in_ready = !bus.out_valid || bus.out_ready;
   assign accept       = bus.in_valid && bus.in_ready;

   decode_lut u_lut (
      .opcode  (bus.in_instr[15:12]),
      .nz6     (bus.in_instr[5:0]),
      .ctrl    (dec_ctrl),
      .imm_sel (dec_imm_sel),
      .illegal (dec_illegal)
   );

   // Immediate extension: fields are first brought to 9 bits, then widened;
   // nz6 is always zero-extended regardless of SEXT_IMM.
   always_comb begin
      sext_en = SEXT_IMM && ((dec_imm_sel == IMM_7) || (dec_imm_sel == IMM_OFF9));
      imm_f9  = '0;
      case (dec_imm_sel)
         IMM_7:    imm_f9 = {{2{bus.in_instr[6] & sext_en}}, bus.in_instr[6:0]};
         IMM_NZ6:  imm_f9 = {3'b000, bus.in_instr[5:0]};
         IMM_OFF9: imm_f9 = bus.in_instr[8:0];
         default:  imm_f9 = '0;
      endcase
      imm_ext = sext_en ? DATA_W'($signed(imm_f9)) : DATA_W'(imm_f9);
   end

   // Output register and counter; flush kills the held bundle and any same-cycle accept.
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.out_valid   <= 1'b0;
         bus.out_ctrl    <= '0;
         bus.out_imm     <= '0;
         bus.out_pc      <= '0;
         bus.out_illegal <= 1'b0;
         ill_count       <= '0;
      end else if (flush) begin
         bus.out_valid <= 1'b0;
      end else if (accept) begin
         bus.out_valid   <= 1'b1;
         bus.out_ctrl    <= dec_ctrl;
         bus.out_imm     <= imm_ext;
         bus.out_pc      <= bus.in_pc;
         bus.out_illegal <= dec_illegal;
         if (dec_illegal && (ill_count != '1)) begin
            ill_count <= ill_count + 1'b1;
         end
      end else if (bus.out_ready) begin
         bus.out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench: two decode stages (sign-extending / 8-bit counter and
// zero-extending / 2-bit counter) driven with identical directed words.
module tb_decode_stage;
   import decode_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       flush;
   logic [7:0] illc_a;
   logic [1:0] illc_b;

   always #5 clk = ~clk;

   decode_stage_if #(.DATA_W(16), .PC_W(8)) ifa ();
   decode_stage_if #(.DATA_W(16), .PC_W(8)) ifb ();

   decode_stage #(.DATA_W(16), .PC_W(8), .SEXT_IMM(1'b1), .ILL_CNT_W(8)) dut_a (
      .clk(clk), .rst(rst), .flush(flush), .bus(ifa), .ill_count(illc_a)
   );
   decode_stage #(.DATA_W(16), .PC_W(8), .SEXT_IMM(1'b0), .ILL_CNT_W(2)) dut_b (
      .clk(clk), .rst(rst), .flush(flush), .bus(ifb), .ill_count(illc_b)
   );

   typedef struct {
      logic [15:0] instr;
      logic [10:0] ctrl;
      logic [15:0] imm_s;
      logic [15:0] imm_z;
      logic        ill;
   } vec_t;

   typedef struct {
      logic [10:0] ctrl;
      logic [15:0] imm;
      logic [7:0]  pc;
      logic        ill;
      logic [7:0]  cnt;
   } exp_t;

   vec_t tab[16];
   exp_t qa[$];
   exp_t qb[$];
   exp_t ea, eb;
   int   checks = 0;
   int   errors = 0;
   int   hs_a = 0;
   int   cyc = 0;
   int   cnt_a_m = 0;
   int   cnt_b_m = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h", name, act, exp);
      end
   endtask

   task automatic set_in(input logic v, input logic [15:0] instr, input logic [7:0] pc);
      ifa.in_valid = v; ifa.in_instr = instr; ifa.in_pc = pc;
      ifb.in_valid = v; ifb.in_instr = instr; ifb.in_pc = pc;
   endtask

   task automatic set_ordy(input logic r);
      ifa.out_ready = r;
      ifb.out_ready = r;
   endtask

   task automatic push(input int idx, input logic [7:0] pc);
      exp_t e;
      if (tab[idx].ill) begin
         if (cnt_a_m < 255) cnt_a_m++;
         if (cnt_b_m < 3)   cnt_b_m++;
      end
      e.ctrl = tab[idx].ctrl;
      e.pc   = pc;
      e.ill  = tab[idx].ill;
      e.imm  = tab[idx].imm_s;
      e.cnt  = 8'(cnt_a_m);
      qa.push_back(e);
      e.imm  = tab[idx].imm_z;
      e.cnt  = 8'(cnt_b_m);
      qb.push_back(e);
   endtask

   // Presents a word and waits (bounded) for it to be accepted; leaves in_valid high.
   task automatic send(input int idx, input logic [7:0] pc);
      logic rdy;
      bit   done;
      done = 1'b0;
      set_in(1'b1, tab[idx].instr, pc);
      for (int n = 0; n < 50 && !done; n++) begin
         @(negedge clk);
         rdy = ifa.in_ready;
         @(posedge clk);
         #1;
         if (rdy) begin
            push(idx, pc);
            done = 1'b1;
         end
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL send_timeout act=stalled exp=accept idx=%0d", idx);
      end
   endtask

   task automatic idle();
      set_in(1'b0, 16'h0000, 8'h00);
   endtask

   task automatic wait_empty();
      bit ok;
      ok = 1'b0;
      for (int n = 0; n < 100 && !ok; n++) begin
         @(negedge clk);
         if (qa.size() == 0 && qb.size() == 0) ok = 1'b1;
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout act=%0d exp=0", qa.size());
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_valid_a"}, 32'(ifa.out_valid),   32'd0);
      chk({tag, "_ctrl_a"},  32'(ifa.out_ctrl),    32'd0);
      chk({tag, "_imm_a"},   32'(ifa.out_imm),     32'd0);
      chk({tag, "_pc_a"},    32'(ifa.out_pc),      32'd0);
      chk({tag, "_ill_a"},   32'(ifa.out_illegal), 32'd0);
      chk({tag, "_cnt_a"},   32'(illc_a),          32'd0);
      chk({tag, "_valid_b"}, 32'(ifb.out_valid),   32'd0);
      chk({tag, "_cnt_b"},   32'(illc_b),          32'd0);
   endtask

   // Monitor A: every completed output handshake is checked against the queue front.
   always @(negedge clk) begin
      if (!rst && ifa.out_valid && ifa.out_ready) begin
         hs_a++;
         if (qa.size() == 0) begin
            chk("a_unexpected_bundle", 32'(ifa.out_pc), 32'hFFFF_FFFF);
         end else begin
            ea = qa.pop_front();
            chk("a_ctrl", 32'(ifa.out_ctrl),    32'(ea.ctrl));
            chk("a_imm",  32'(ifa.out_imm),     32'(ea.imm));
            chk("a_pc",   32'(ifa.out_pc),      32'(ea.pc));
            chk("a_ill",  32'(ifa.out_illegal), 32'(ea.ill));
            chk("a_cnt",  32'(illc_a),          32'(ea.cnt));
         end
      end
   end

   // Monitor B: same, zero-extending instance with 2-bit counter.
   always @(negedge clk) begin
      if (!rst && ifb.out_valid && ifb.out_ready) begin
         if (qb.size() == 0) begin
            chk("b_unexpected_bundle", 32'(ifb.out_pc), 32'hFFFF_FFFF);
         end else begin
            eb = qb.pop_front();
            chk("b_ctrl", 32'(ifb.out_ctrl),    32'(eb.ctrl));
            chk("b_imm",  32'(ifb.out_imm),     32'(eb.imm));
            chk("b_pc",   32'(ifb.out_pc),      32'(eb.pc));
            chk("b_ill",  32'(ifb.out_illegal), 32'(eb.ill));
            chk("b_cnt",  32'(illc_b),          32'(eb.cnt));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog act=running exp=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0, c1, base;
      tab[0]  = '{16'h0045, 11'b1101010_0000, 16'hFFC5, 16'h0045, 1'b0};
      tab[1]  = '{16'hA1FF, 11'b0010000_0110, 16'hFFFF, 16'h01FF, 1'b0};
      tab[2]  = '{16'h1A3C, 11'b0001100_0000, 16'h003C, 16'h003C, 1'b0};
      tab[3]  = '{16'h2123, 11'b1100001_0000, 16'h0000, 16'h0000, 1'b0};
      tab[4]  = '{16'h3005, 11'b1101001_0000, 16'h0005, 16'h0005, 1'b0};
      tab[5]  = '{16'h3000, 11'b0000000_0000, 16'h0000, 16'h0000, 1'b1};
      tab[6]  = '{16'hC000, 11'b0000000_0000, 16'h0000, 16'h0000, 1'b1};
      tab[7]  = '{16'h5F7F, 11'b1101001_0010, 16'hFFFF, 16'h007F, 1'b0};
      tab[8]  = '{16'h8040, 11'b0000000_0000, 16'h0000, 16'h0000, 1'b1};
      tab[9]  = '{16'h9FFF, 11'b1101001_0101, 16'h003F, 16'h003F, 1'b0};
      tab[10] = '{16'hB100, 11'b0010000_0111, 16'hFF00, 16'h0100, 1'b0};
      tab[11] = '{16'h4ABC, 11'b1100001_0010, 16'h0000, 16'h0000, 1'b0};
      tab[12] = '{16'h6000, 11'b1100001_0011, 16'h0000, 16'h0000, 1'b0};
      tab[13] = '{16'h7000, 11'b1100001_1000, 16'h0000, 16'h0000, 1'b0};
      tab[14] = '{16'hFFFF, 11'b0000000_0000, 16'h0000, 16'h0000, 1'b1};
      tab[15] = '{16'h2000, 11'b1100001_0000, 16'h0000, 16'h0000, 1'b0};

      rst = 1'b1;
      flush = 1'b0;
      idle();
      set_ordy(1'b1);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk_zero("reset");
      @(posedge clk); #1;

      // LD / branch extension, then the rest of the table including illegals
      for (int i = 0; i < 14; i++) send(i, 8'h10 + 8'(i));
      send(14, 8'h1E);
      send(6, 8'h1F);
      idle();
      wait_empty();
      chk("cnt_a_after5", 32'(illc_a), 32'd5);
      chk("cnt_b_sat",    32'(illc_b), 32'd3);

      // Stall: held bundle stable, in_ready low, then drain+reload
      @(posedge clk); #1;
      set_ordy(1'b0);
      send(0, 8'h30);
      set_in(1'b1, tab[7].instr, 8'h31);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("stall_in_ready", 32'(ifa.in_ready),  32'd0);
         chk("stall_valid",    32'(ifa.out_valid), 32'd1);
         chk("stall_ctrl",     32'(ifa.out_ctrl),  32'(11'b1101010_0000));
         chk("stall_imm_a",    32'(ifa.out_imm),   32'hFFC5);
         chk("stall_imm_b",    32'(ifb.out_imm),   32'h0045);
         chk("stall_pc",       32'(ifa.out_pc),    32'h30);
         @(posedge clk); #1;
      end
      set_ordy(1'b1);
      send(7, 8'h31);
      idle();
      @(negedge clk);
      chk("reload_valid", 32'(ifa.out_valid), 32'd1);
      chk("reload_pc",    32'(ifa.out_pc),    32'h31);
      wait_empty();

      // Flush with a held bundle and an incoming word
      @(posedge clk); #1;
      set_ordy(1'b0);
      send(4, 8'h40);
      set_in(1'b1, tab[15].instr, 8'h41);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      idle();
      void'(qa.pop_front());
      void'(qb.pop_front());
      @(negedge clk);
      chk("flush_valid_a", 32'(ifa.out_valid), 32'd0);
      chk("flush_valid_b", 32'(ifb.out_valid), 32'd0);
      chk("flush_cnt_a",   32'(illc_a),        32'd5);
      // Flush discards an accepted illegal word without counting it
      set_ordy(1'b1);
      @(posedge clk); #1;
      set_in(1'b1, tab[6].instr, 8'h42);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      idle();
      @(negedge clk);
      chk("flush2_valid", 32'(ifa.out_valid), 32'd0);
      chk("flush2_cnt_a", 32'(illc_a),        32'd5);

      // Reset during a stall drops the held bundle
      @(posedge clk); #1;
      set_ordy(1'b0);
      send(9, 8'h50);
      idle();
      @(negedge clk);
      chk("pre_rst_valid", 32'(ifa.out_valid), 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      qa.delete();
      qb.delete();
      cnt_a_m = 0;
      cnt_b_m = 0;
      @(negedge clk);
      chk_zero("midrst");

      // Back-to-back stream at full throughput
      set_ordy(1'b1);
      @(posedge clk); #1;
      base = hs_a;
      c0 = cyc;
      for (int i = 0; i < 10; i++) send(i, 8'h60 + 8'(i));
      idle();
      c1 = cyc;
      chk("stream_cycles", 32'(c1 - c0), 32'd10);
      repeat (2) @(negedge clk);
      chk("stream_bundles", 32'(hs_a - base), 32'd10);
      chk("stream_end_valid", 32'(ifa.out_valid), 32'd0);
      chk("stream_cnt_a", 32'(illc_a), 32'd3);

      wait_empty();
      chk("queue_a_left", 32'(qa.size()), 32'd0);
      chk("queue_b_left", 32'(qb.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
